// File: rtl/peak_meter_pkg.sv
// Shared types and helpers for the peak meter.
//   NUM_CH / WIDTH : channel count and signed sample width of the audio bus
//   sample_t       : one signed audio sample
//   level_t        : unsigned magnitude (one bit narrower than a sample)
//   audio_frame_t  : one frame of NUM_CH samples as delivered on the bus
//   state_e        : peak meter sequencer states
//   led_bar()      : bar-graph encoding of a level plus the clip indicator
package peak_meter_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned WIDTH  = 24;
  localparam int unsigned IDX_W  = $clog2(NUM_CH);

  typedef logic signed [WIDTH-1:0] sample_t;
  typedef logic        [WIDTH-2:0] level_t;
  typedef sample_t     [0:NUM_CH-1] audio_frame_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  // One LED per octave from 2^16 upwards; the top LED shows the clip flag.
  function automatic logic [7:0] led_bar(level_t peak, logic clip_bit);
    logic [7:0] bar;
    for (int k = 0; k < 7; k++) begin
      bar[k] = (peak >= (level_t'(1) << (16 + k)));
    end
    bar[7] = clip_bit;
    return bar;
  endfunction

endpackage

// File: rtl/peak_meter_abs_sat.sv
// Saturating absolute value of a signed sample.
//   x_i : signed sample
//   a_o : |x_i|, with the most negative sample clamped to the largest level
module peak_meter_abs_sat
  import peak_meter_pkg::*;
(
  input  sample_t x_i,
  output level_t  a_o
);

  localparam sample_t MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  always_comb begin
    if (x_i == MinVal) begin
      a_o = '1;
    end else if (x_i[WIDTH-1]) begin
      a_o = level_t'(-x_i);
    end else begin
      a_o = level_t'(x_i);
    end
  end

endmodule

// File: rtl/peak_meter.sv
// Per-channel peak meter with hold, exponential decay and sticky clip/overrun flags.
// Channels are scanned serially (one per clock) through a single abs/compare datapath.
//   clk, rst_n  : clock, asynchronous active-low reset
//   data_valid  : one-cycle strobe, audio_bus carries a new frame
//   audio_bus   : NUM_CH signed samples
//   chan_sel    : channel shown on led / peak_out
//   clip_clear  : clears all clip flags and overrun
//   led         : bar graph of the selected channel (bit 7 = its clip flag)
//   peak_out    : current peak of the selected channel
//   clip        : sticky per-channel clip flags
//   overrun     : sticky, a frame arrived while a scan was in progress
//   frame_done  : one-cycle pulse when led / peak_out take a scan result
module peak_meter
  import peak_meter_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 4800,
  parameter int unsigned DECAY_SHIFT = 6,
  parameter level_t      CLIP_LEVEL  = level_t'(24'h7FFF00)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_valid,
  input  audio_frame_t      audio_bus,
  input  logic [IDX_W-1:0]  chan_sel,
  input  logic              clip_clear,
  output logic [7:0]        led,
  output level_t            peak_out,
  output logic [NUM_CH-1:0] clip,
  output logic              overrun,
  output logic              frame_done
);

  localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  audio_frame_t       frame_q;
  level_t             peak_q [NUM_CH];
  logic [HoldW-1:0]   hold_q [NUM_CH];
  logic [7:0]         led_q, led_d;
  level_t             peak_out_q, peak_out_d;
  logic [NUM_CH-1:0]  clip_q, clip_d;
  logic               overrun_q, overrun_d;
  logic               frame_done_q, frame_done_d;

  logic               latch_en, scan_en, out_en;
  level_t             cur_a, cur_peak, decay, peak_new;
  logic [HoldW-1:0]   cur_hold, hold_new;

  // Shared datapath for the channel being scanned.
  peak_meter_abs_sat u_abs_sat (
    .x_i (frame_q[idx_q]),
    .a_o (cur_a)
  );

  assign cur_peak = peak_q[idx_q];
  assign cur_hold = hold_q[idx_q];
  assign decay    = cur_peak >> DECAY_SHIFT;

  always_comb begin
    peak_new = cur_peak;
    hold_new = cur_hold;
    if (cur_a >= cur_peak) begin
      peak_new = cur_a;
      hold_new = HoldW'(HOLD_FRAMES);
    end else if (cur_hold != '0) begin
      hold_new = cur_hold - HoldW'(1);
    end else if (decay != '0) begin
      peak_new = cur_peak - decay;
    end else if (cur_peak != '0) begin
      // Small peaks would never reach zero through the shift alone.
      peak_new = cur_peak - level_t'(1);
    end
  end

  // Sequencer: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sequencer: next state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (data_valid) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_CH - 1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sequencer: outputs and flag next-state.
  always_comb begin
    latch_en = (state_q == StIdle) && data_valid;
    scan_en  = (state_q == StScan);
    out_en   = (state_q != StScan);

    // Sets are OR-ed in after the clear so a same-cycle set wins.
    clip_d = clip_clear ? '0 : clip_q;
    if (scan_en && (cur_a >= CLIP_LEVEL)) begin
      clip_d[idx_q] = 1'b1;
    end
    overrun_d = (clip_clear ? 1'b0 : overrun_q) | (data_valid && (state_q != StIdle));

    peak_out_d   = peak_q[chan_sel];
    led_d        = led_bar(peak_q[chan_sel], clip_d[chan_sel]);
    frame_done_d = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q      <= '0;
      led_q        <= '0;
      peak_out_q   <= '0;
      clip_q       <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        peak_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      if (latch_en) begin
        frame_q <= audio_bus;
      end
      if (scan_en) begin
        peak_q[idx_q] <= peak_new;
        hold_q[idx_q] <= hold_new;
      end
      if (out_en) begin
        led_q      <= led_d;
        peak_out_q <= peak_out_d;
      end
      clip_q       <= clip_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign led        = led_q;
  assign peak_out   = peak_out_q;
  assign clip       = clip_q;
  assign overrun    = overrun_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_peak_meter.sv
module tb_peak_meter;
  import peak_meter_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              data_valid;
  audio_frame_t      audio_bus;
  logic [IDX_W-1:0]  chan_sel;
  logic              clip_clear;
  logic [7:0]        led;
  level_t            peak_out;
  logic [NUM_CH-1:0] clip;
  logic              overrun;
  logic              frame_done;

  int checks = 0;
  int passes = 0;

  peak_meter #(
    .HOLD_FRAMES (2),
    .DECAY_SHIFT (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .audio_bus  (audio_bus),
    .chan_sel   (chan_sel),
    .clip_clear (clip_clear),
    .led        (led),
    .peak_out   (peak_out),
    .clip       (clip),
    .overrun    (overrun),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    data_valid = 1'b0;
    clip_clear = 1'b0;
    audio_bus  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one frame and waits (bounded) for frame_done; lat = edges after E0, -1 on timeout.
  task automatic run_frame(input audio_frame_t b, output int lat);
    @(negedge clk);
    audio_bus  = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    audio_frame_t b;
    int lat;
    #1;
    checks++; if (led !== 8'h00) $display("FAIL reset_led: got %h want 00", led); else passes++;
    checks++; if (peak_out !== 23'h0) $display("FAIL reset_peak: got %h want 0", peak_out); else passes++;
    checks++; if (clip !== 8'h00) $display("FAIL reset_clip: got %h want 00", clip); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    chan_sel = 3'd0;
    b = '0;
    b[0] = 24'h400000;
    run_frame(b, lat);
    checks++; if (peak_out !== 23'h400000) $display("FAIL pre_reset_peak: got %h want 400000", peak_out); else passes++;
    checks++; if (led !== 8'h7F) $display("FAIL pre_reset_led: got %h want 7f", led); else passes++;
    // Assert reset mid-scan, between clock edges.
    @(negedge clk);
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (led !== 8'h00) $display("FAIL async_reset_led: got %h want 00", led); else passes++;
    checks++; if (peak_out !== 23'h0) $display("FAIL async_reset_peak: got %h want 0", peak_out); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_frame();
    audio_frame_t b;
    int lat;
    chan_sel = 3'd2;
    b = '0;
    b[2] = 24'h010000;
    run_frame(b, lat);
    checks++; if (lat !== 9) $display("FAIL first_latency: got %0d want 9", lat); else passes++;
    checks++; if (led !== 8'h01) $display("FAIL first_led: got %h want 01", led); else passes++;
    checks++; if (peak_out !== 23'd65536) $display("FAIL first_peak: got %0d want 65536", peak_out); else passes++;
    @(posedge clk);
    #1;
    checks++; if (frame_done !== 1'b0) $display("FAIL first_done_pulse: got %b want 0", frame_done); else passes++;
  endtask

  task automatic test_saturation();
    audio_frame_t b;
    int lat;
    do_reset();
    chan_sel = 3'd0;
    b = '0;
    b[0] = 24'h800000;
    run_frame(b, lat);
    checks++; if (peak_out !== 23'h7FFFFF) $display("FAIL sat_peak: got %h want 7fffff", peak_out); else passes++;
    checks++; if (clip !== 8'h01) $display("FAIL sat_clip: got %h want 01", clip); else passes++;
    checks++; if (led !== 8'hFF) $display("FAIL sat_led: got %h want ff", led); else passes++;
    @(negedge clk);
    clip_clear = 1'b1;
    @(negedge clk);
    clip_clear = 1'b0;
    @(negedge clk);
    checks++; if (clip !== 8'h00) $display("FAIL clear_clip: got %h want 00", clip); else passes++;
    checks++; if (led !== 8'h7F) $display("FAIL clear_led: got %h want 7f", led); else passes++;
  endtask

  task automatic test_hold_decay();
    audio_frame_t b;
    int lat;
    level_t ep;
    logic [7:0] el;
    do_reset();
    chan_sel = 3'd3;
    for (int k = 1; k <= 27; k++) begin
      b = '0;
      if (k == 1) b[3] = 24'h400000;
      run_frame(b, lat);
      if (k <= 3) ep = 23'h400000;
      else if (k <= 25) ep = level_t'(1) << (25 - k);
      else ep = '0;
      el = '0;
      for (int j = 0; j < 7; j++) el[j] = (ep >= (level_t'(1) << (16 + j)));
      checks++; if (peak_out !== ep) $display("FAIL decay_peak_f%0d: got %h want %h", k, peak_out, ep); else passes++;
      checks++; if (led !== el) $display("FAIL decay_led_f%0d: got %h want %h", k, led, el); else passes++;
    end
  endtask

  task automatic test_overrun();
    audio_frame_t b1, b2;
    int lat, cnt;
    level_t pk;
    logic [7:0] ld;
    do_reset();
    chan_sel = 3'd1;
    b1 = '0;
    b1[1] = 24'h123456;
    b2 = '0;
    b2[1] = 24'h7FFFFF;
    @(negedge clk);
    audio_bus  = b1;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    lat = -1;
    cnt = 0;
    pk = '0;
    ld = '0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 4) begin
        audio_bus  = b2;
        data_valid = 1'b1;
      end
      @(posedge clk);
      #1 data_valid = 1'b0;
      if (frame_done) begin
        cnt++;
        if (cnt == 1) begin
          lat = n;
          pk = peak_out;
          ld = led;
        end
      end
    end
    checks++; if (cnt !== 1) $display("FAIL ovr_done_count: got %0d want 1", cnt); else passes++;
    checks++; if (lat !== 9) $display("FAIL ovr_latency: got %0d want 9", lat); else passes++;
    checks++; if (pk !== 23'h123456) $display("FAIL ovr_peak: got %h want 123456", pk); else passes++;
    checks++; if (ld !== 8'h1F) $display("FAIL ovr_led: got %h want 1f", ld); else passes++;
    checks++; if (clip !== 8'h00) $display("FAIL ovr_clip: got %h want 00", clip); else passes++;
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passes++;
    @(negedge clk);
    clip_clear = 1'b1;
    @(negedge clk);
    clip_clear = 1'b0;
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else passes++;
  endtask

  task automatic test_set_wins();
    audio_frame_t b;
    int lat;
    do_reset();
    chan_sel = 3'd5;
    b = '0;
    b[5] = 24'h7FFFFF;
    @(negedge clk);
    clip_clear = 1'b1;
    audio_bus  = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (5) @(posedge clk);
    // Channel 5 is scanned on the next edge; a frame drop lands on it too.
    #1 data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    clip_clear = 1'b0;
    lat = -1;
    for (int n = 7; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat !== 9) $display("FAIL setwin_latency: got %0d want 9", lat); else passes++;
    checks++; if (clip !== 8'h20) $display("FAIL setwin_clip: got %h want 20", clip); else passes++;
    checks++; if (overrun !== 1'b1) $display("FAIL setwin_overrun: got %b want 1", overrun); else passes++;
    checks++; if (led !== 8'hFF) $display("FAIL setwin_led: got %h want ff", led); else passes++;
  endtask

  task automatic test_chan_sweep();
    audio_frame_t b;
    level_t exp_pk [NUM_CH];
    int lat;
    do_reset();
    chan_sel = 3'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_pk[i] = level_t'((i + 1) * 65536 + i);
      b[i] = (i % 2 == 1) ? -sample_t'(exp_pk[i]) : sample_t'(exp_pk[i]);
    end
    run_frame(b, lat);
    checks++; if (peak_out !== exp_pk[0]) $display("FAIL sweep_ch0: got %h want %h", peak_out, exp_pk[0]); else passes++;
    for (int i = 1; i < NUM_CH; i++) begin
      @(negedge clk);
      chan_sel = IDX_W'(i);
      #1;
      checks++; if (peak_out !== exp_pk[i-1]) $display("FAIL sweep_hold_ch%0d: got %h want %h", i, peak_out, exp_pk[i-1]); else passes++;
      @(posedge clk);
      #1;
      checks++; if (peak_out !== exp_pk[i]) $display("FAIL sweep_ch%0d: got %h want %h", i, peak_out, exp_pk[i]); else passes++;
    end
    // Outputs stay frozen while a scan is in flight.
    b = '0;
    @(negedge clk);
    audio_bus  = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    chan_sel   = 3'd0;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk);
      #1;
      checks++; if (peak_out !== exp_pk[7]) $display("FAIL scan_frozen_%0d: got %h want %h", n, peak_out, exp_pk[7]); else passes++;
    end
    lat = -1;
    for (int n = 4; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat !== 9) $display("FAIL scan_latency: got %0d want 9", lat); else passes++;
    checks++; if (peak_out !== exp_pk[0]) $display("FAIL scan_after: got %h want %h", peak_out, exp_pk[0]); else passes++;
  endtask

  initial begin
    rst_n      = 1'b0;
    data_valid = 1'b0;
    clip_clear = 1'b0;
    chan_sel   = '0;
    audio_bus  = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_first_frame();
    test_saturation();
    test_hold_decay();
    test_overrun();
    test_set_wins();
    test_chan_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
